// File: rtl/eth_rx_frame_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_frame_sched_pkg
//  Purpose  : Shared widths, frame-length limits and sequencer state encoding
//             for the Ethernet RX frame buffer read side (also used by the
//             RX writer).
//  Options  : ETH_RX_LEN_CHECK_EN adds the DROP state.
//  Revision : 1.0  initial release
// ============================================================================
package eth_rx_frame_sched_pkg;

    localparam int c_data_w  = 8;     // one byte per data FIFO line
    localparam int c_len_w   = 11;    // length entry width, bytes
    localparam int c_min_len = 64;    // smallest legal frame, bytes
    localparam int c_max_len = 1518;  // largest legal frame, bytes

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_POP = 3'd1,
        ST_LEN_CAP = 3'd2,
        ST_STREAM  = 3'd3
`ifdef ETH_RX_LEN_CHECK_EN
        ,ST_DROP   = 3'd4
`endif
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_rx_frame_sched_skid.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_skid_buf
//  Purpose  : 2-entry registered buffer with valid/ready on both sides and
//             an occupancy count. Output is always driven from a register.
//  Ports    : i_sys_clk/i_rstn       clock, synchronous active-low reset
//             i_in_valid/o_in_ready  write side handshake, i_in_data payload
//             o_out_valid/i_out_ready read side handshake, o_out_data payload
//             o_count                entries held (0..2)
//  Revision : 1.0  initial release
// ============================================================================
module eth_rx_skid_buf
    import eth_rx_frame_sched_pkg::*;
#(
    parameter int WIDTH = c_data_w + 2
) (
    input  logic             i_sys_clk,
    input  logic             i_rstn,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem0;   // head entry, drives the output
    logic [WIDTH-1:0] r_mem1;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_out_valid = (r_count != 2'd0);
    assign o_out_data  = r_mem0;
    assign o_count     = r_count;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign o_in_ready  = (r_count != 2'd2) || i_out_ready;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    always_ff @(posedge i_sys_clk) begin
        if (!i_rstn) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= i_in_data;
                    else                 r_mem1 <= i_in_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_in_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_rx_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_frame_sched
//  Purpose  : Read-side sequencer of the RX frame buffer. Pops a frame
//             length, then exactly that many data lines, and presents them
//             downstream as a valid/ready stream framed with SOF/EOF.
//  Ports    : i_sys_clk, i_rstn (synchronous, active low)
//             o_len_fifo_r_en / i_len_fifo_empty / i_len_fifo_data
//             o_data_fifo_r_en / i_data_fifo_empty / i_data_fifo_data
//             o_frm_valid/o_frm_data/o_frm_sof/o_frm_eof, i_frm_ready
//             o_frm_drop (illegal-length frame discarded), o_busy
//  Options  : ETH_RX_LEN_CHECK_EN - frames outside MIN_LEN..MAX_LEN are
//             drained from the data FIFO and reported on o_frm_drop.
//  Revision : 1.0  initial release
// ============================================================================
module eth_rx_frame_sched
    import eth_rx_frame_sched_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int LEN_W   = c_len_w,
    parameter int MIN_LEN = c_min_len,
    parameter int MAX_LEN = c_max_len
) (
    input  logic              i_sys_clk,
    input  logic              i_rstn,
    output logic              o_len_fifo_r_en,
    input  logic              i_len_fifo_empty,
    input  logic [LEN_W-1:0]  i_len_fifo_data,
    output logic              o_data_fifo_r_en,
    input  logic              i_data_fifo_empty,
    input  logic [DATA_W-1:0] i_data_fifo_data,
    output logic              o_frm_valid,
    output logic [DATA_W-1:0] o_frm_data,
    output logic              o_frm_sof,
    output logic              o_frm_eof,
    input  logic              i_frm_ready,
    output logic              o_frm_drop,
    output logic              o_busy
);

    sched_state_t     r_state;
    logic             r_len_r_en;
    logic [LEN_W-1:0] r_rem;       // data lines still to pop for this frame
    logic             r_first;     // next pop is the frame's first line
    logic             r_inflight;  // a popped line arrives this cycle
    logic             r_inf_sof;
    logic             r_inf_eof;

    logic             w_stream_pop;
    logic             w_drop_pop;
    logic             w_last_pop;
    logic             w_skid_in_ready;
    logic [1:0]       w_skid_cnt;
    logic             w_skid_deq;
    logic [1:0]       w_load;

    // Occupancy seen by the pop rule excludes a beat leaving this cycle, so
    // one pop per cycle is sustained while ready is held high.
    assign w_skid_deq   = o_frm_valid && i_frm_ready;
    assign w_load       = {1'b0, r_inflight} + w_skid_cnt - {1'b0, w_skid_deq};
    assign w_stream_pop = (r_state == ST_STREAM) && !i_data_fifo_empty &&
                          (r_rem != '0) && (w_load < 2'd2);

`ifdef ETH_RX_LEN_CHECK_EN
    logic w_len_illegal;
    assign w_len_illegal = (int'(i_len_fifo_data) < MIN_LEN) ||
                           (int'(i_len_fifo_data) > MAX_LEN);
    assign w_drop_pop    = (r_state == ST_DROP) && !i_data_fifo_empty && (r_rem != '0);
    assign o_frm_drop    = w_drop_pop && (r_rem == LEN_W'(1));
`else
    assign w_drop_pop    = 1'b0;
    assign o_frm_drop    = 1'b0;
`endif

    assign o_data_fifo_r_en = w_stream_pop || w_drop_pop;
    assign w_last_pop       = o_data_fifo_r_en && (r_rem == LEN_W'(1));
    assign o_len_fifo_r_en  = r_len_r_en;
    assign o_busy           = (r_state != ST_IDLE);

    always_ff @(posedge i_sys_clk) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_len_r_en <= 1'b0;
            r_rem      <= '0;
            r_first    <= 1'b0;
            r_inflight <= 1'b0;
            r_inf_sof  <= 1'b0;
            r_inf_eof  <= 1'b0;
        end else begin
            r_len_r_en <= 1'b0;
            r_inflight <= w_stream_pop;
            // Frame markers are fixed at pop time so an overlapping next
            // frame cannot disturb beats still draining from the skid.
            if (w_stream_pop) begin
                r_inf_sof <= r_first;
                r_inf_eof <= (r_rem == LEN_W'(1));
                r_first   <= 1'b0;
            end
            if (o_data_fifo_r_en) r_rem <= r_rem - LEN_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (!i_len_fifo_empty) begin
                        r_state    <= ST_LEN_POP;
                        r_len_r_en <= 1'b1;
                    end
                end
                ST_LEN_POP: r_state <= ST_LEN_CAP;
                ST_LEN_CAP: begin
                    // Length entry is on the bus the cycle after its pop.
                    r_rem   <= i_len_fifo_data;
                    r_first <= 1'b1;
                    if (i_len_fifo_data == '0)
                        r_state <= ST_IDLE;
`ifdef ETH_RX_LEN_CHECK_EN
                    else if (w_len_illegal)
                        r_state <= ST_DROP;
`endif
                    else
                        r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    // Start the next length pop right behind the last data
                    // pop when one is waiting; otherwise drain fully first.
                    if (w_last_pop && !i_len_fifo_empty) begin
                        r_state    <= ST_LEN_POP;
                        r_len_r_en <= 1'b1;
                    end else if ((r_rem == '0) && !r_inflight && (w_skid_cnt == 2'd0)) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef ETH_RX_LEN_CHECK_EN
                ST_DROP: begin
                    if (w_last_pop) r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    eth_rx_skid_buf #(
        .WIDTH (DATA_W + 2)
    ) u_skid (
        .i_sys_clk   (i_sys_clk),
        .i_rstn      (i_rstn),
        .i_in_valid  (r_inflight && w_skid_in_ready),
        .o_in_ready  (w_skid_in_ready),
        .i_in_data   ({r_inf_sof, r_inf_eof, i_data_fifo_data}),
        .o_out_valid (o_frm_valid),
        .i_out_ready (i_frm_ready),
        .o_out_data  ({o_frm_sof, o_frm_eof, o_frm_data}),
        .o_count     (w_skid_cnt)
    );

endmodule
`default_nettype wire
